// File: rtl/fifo_sync_8bit.sv
// Single-clock byte FIFO with registered read data and pointer-derived full/empty flags.
// Pointers carry one extra MSB so a full FIFO can be told apart from an empty one.
module fifo_sync_8bit #(
  parameter int pFifoDepth = 8
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iWrEn,
  output logic       oWrFull,
  input  logic [7:0] iWrData,
  input  logic       iRdEn,
  output logic       oRdEmpty,
  output logic [7:0] oRdData
);

  localparam int cAddrW = $clog2(pFifoDepth);

  logic [7:0]      mem [pFifoDepth];
  logic [cAddrW:0] wrPtr;
  logic [cAddrW:0] rdPtr;
  logic            wrAccept;
  logic            rdAccept;

  assign oRdEmpty = (wrPtr == rdPtr);
  assign oWrFull  = (wrPtr[cAddrW] != rdPtr[cAddrW]) &&
                    (wrPtr[cAddrW-1:0] == rdPtr[cAddrW-1:0]);

  // Reset wins over any request issued in the same cycle.
  assign wrAccept = iWrEn && !oWrFull && !iRst;
  assign rdAccept = iRdEn && !oRdEmpty && !iRst;

  always_ff @(posedge iClk) begin
    if (wrAccept) begin
      mem[wrPtr[cAddrW-1:0]] <= iWrData;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      oRdData <= 8'h00;
    end else begin
      if (wrAccept) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (rdAccept) begin
        oRdData <= mem[rdPtr[cAddrW-1:0]];
        rdPtr   <= rdPtr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_8bit.sv
// Bench for fifo_sync_8bit: directed scenarios plus a randomized run, all checked
// against a queue-based model of FIFO contents and the last popped byte.
module tb_fifo_sync_8bit;

  localparam int DEPTH = 8;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic       iWrEn = 1'b0;
  logic       oWrFull;
  logic [7:0] iWrData = 8'h00;
  logic       iRdEn = 1'b0;
  logic       oRdEmpty;
  logic [7:0] oRdData;

  int nTests = 0;
  int nFail  = 0;

  logic [7:0] model [$];
  logic [7:0] mData = 8'h00;

  fifo_sync_8bit #(.pFifoDepth(DEPTH)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iWrEn   (iWrEn),
    .oWrFull (oWrFull),
    .iWrData (iWrData),
    .iRdEn   (iRdEn),
    .oRdEmpty(oRdEmpty),
    .oRdData (oRdData)
  );

  always #5 iClk = ~iClk;

  // One clock cycle: apply inputs, clock, then advance the model using pre-edge occupancy.
  task automatic drive(input logic we, input logic [7:0] wd, input logic re, input logic rst);
    bit wAcc, rAcc;
    iWrEn = we; iWrData = wd; iRdEn = re; iRst = rst;
    wAcc = we && !rst && (model.size() < DEPTH);
    rAcc = re && !rst && (model.size() > 0);
    @(posedge iClk);
    #1;
    if (rst) begin
      model.delete();
      mData = 8'h00;
    end else begin
      if (rAcc) mData = model.pop_front();
      if (wAcc) model.push_back(wd);
    end
    iWrEn = 1'b0; iRdEn = 1'b0; iRst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 8'hFF, 1'b1, 1'b1);
    drive(1'b1, 8'hFF, 1'b1, 1'b1);
    nTests++; if (oRdEmpty !== 1'b1) begin nFail++; $display("FAIL reset_empty got %b want 1", oRdEmpty); end
    nTests++; if (oWrFull !== 1'b0) begin nFail++; $display("FAIL reset_full got %b want 0", oWrFull); end
    nTests++; if (oRdData !== 8'h00) begin nFail++; $display("FAIL reset_data got %h want 00", oRdData); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    nTests++; if (oRdData !== 8'h00 || oRdEmpty !== 1'b1) begin
      nFail++; $display("FAIL reset_nowrite data=%h empty=%b want 00/1", oRdData, oRdEmpty);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i + 1), 1'b0, 1'b0);
      nTests++; if (oWrFull !== (i == DEPTH - 1) || oRdEmpty !== 1'b0) begin
        nFail++; $display("FAIL fill_flags i=%0d full=%b empty=%b", i, oWrFull, oRdEmpty);
      end
    end
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    nTests++; if (oWrFull !== 1'b1) begin nFail++; $display("FAIL fill_drop_full got %b want 1", oWrFull); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      nTests++; if (oRdData !== 8'(i + 1) || oRdData !== mData) begin
        nFail++; $display("FAIL drain_data i=%0d got %h want %h", i, oRdData, 8'(i + 1));
      end
      nTests++; if (oWrFull !== 1'b0) begin nFail++; $display("FAIL drain_full i=%0d got %b want 0", i, oWrFull); end
    end
    nTests++; if (oRdEmpty !== 1'b1) begin nFail++; $display("FAIL drain_empty got %b want 1", oRdEmpty); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    nTests++; if (oRdData !== 8'h08) begin nFail++; $display("FAIL empty_read_hold got %h want 08", oRdData); end
  endtask

  task automatic test_wraparound();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      nTests++; if (oRdData !== 8'(8'h30 + i)) begin nFail++; $display("FAIL wrap_pre i=%0d got %h want %h", i, oRdData, 8'(8'h30 + i)); end
    end
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    nTests++; if (oWrFull !== 1'b1) begin nFail++; $display("FAIL wrap_full got %b want 1", oWrFull); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      nTests++; if (oRdData !== 8'(8'h10 + i) || oRdData !== mData) begin
        nFail++; $display("FAIL wrap_data i=%0d got %h want %h", i, oRdData, 8'(8'h10 + i));
      end
    end
    nTests++; if (oRdEmpty !== 1'b1) begin nFail++; $display("FAIL wrap_empty got %b want 1", oRdEmpty); end
  endtask

  task automatic test_simultaneous_mid();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'h43 + i), 1'b1, 1'b0);
      nTests++; if (oRdData !== 8'(8'h40 + i) || oRdEmpty !== 1'b0 || oWrFull !== 1'b0) begin
        nFail++; $display("FAIL sim_mid i=%0d data=%h want %h empty=%b full=%b", i, oRdData, 8'(8'h40 + i), oRdEmpty, oWrFull);
      end
    end
    nTests++; if (model.size() != 3) begin nFail++; $display("FAIL sim_mid_count got %0d want 3", model.size()); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      nTests++; if (oRdData !== 8'(8'h54 + i)) begin nFail++; $display("FAIL sim_mid_drain i=%0d got %h want %h", i, oRdData, 8'(8'h54 + i)); end
    end
  endtask

  task automatic test_simultaneous_full_empty();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    nTests++; if (oRdData !== 8'h60 || oWrFull !== 1'b0) begin
      nFail++; $display("FAIL sim_full data=%h full=%b want 60/0", oRdData, oWrFull);
    end
    for (int i = 1; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      nTests++; if (oRdData !== 8'(8'h60 + i)) begin nFail++; $display("FAIL sim_full_drain i=%0d got %h want %h", i, oRdData, 8'(8'h60 + i)); end
    end
    nTests++; if (oRdEmpty !== 1'b1) begin nFail++; $display("FAIL sim_full_dropped empty=%b want 1", oRdEmpty); end
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    nTests++; if (oRdData !== 8'h67 || oRdEmpty !== 1'b0) begin
      nFail++; $display("FAIL sim_empty data=%h empty=%b want 67/0", oRdData, oRdEmpty);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    nTests++; if (oRdData !== 8'hAA || oRdEmpty !== 1'b1) begin
      nFail++; $display("FAIL sim_empty_read data=%h empty=%b want AA/1", oRdData, oRdEmpty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    nTests++; if (oRdEmpty !== 1'b1 || oWrFull !== 1'b0 || oRdData !== 8'h00) begin
      nFail++; $display("FAIL rst_mid empty=%b full=%b data=%h want 1/0/00", oRdEmpty, oWrFull, oRdData);
    end
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    nTests++; if (oRdData !== 8'h5A || oRdEmpty !== 1'b1) begin
      nFail++; $display("FAIL rst_mid_read data=%h empty=%b want 5A/1", oRdData, oRdEmpty);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
      nTests++; if (oRdData !== mData || oRdEmpty !== (model.size() == 0) || oWrFull !== (model.size() == DEPTH)) begin
        nFail++; $display("FAIL random i=%0d data=%h want %h empty=%b full=%b count=%0d", i, oRdData, mData, oRdEmpty, oWrFull, model.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wraparound();
    test_simultaneous_mid();
    test_simultaneous_full_empty();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
